// File: rtl/j_fetch_unit.sv
// j_fetch_unit
// Fills the J1/J2 halves of the jump-target register from memory. A start
// pulse in IDLE latches the operand address, then two byte reads are issued
// over a req/ack handshake: J1 (high byte) at base, J2 (low byte) at base+1.
// When J2 lands, {j1,j2} is flagged valid and a one-cycle done pulse fires.
//
// Ports
//   i_clock      system clock, rising edge
//   i_reset      synchronous active-high reset
//   i_start      fetch request, honoured only in IDLE
//   i_abort      cancels an in-progress fetch
//   i_oper_addr  address of the J1 byte
//   o_mem_req    read request, held until i_mem_ack
//   o_mem_addr   read address, stable while o_mem_req=1
//   i_mem_ack    read complete, i_mem_rdata valid this cycle
//   i_mem_rdata  read data byte
//   o_j1, o_j2   captured high / low bytes
//   o_j_valid    {o_j1,o_j2} is a complete target from one fetch
//   o_busy       high while fetching
//   o_done       one-cycle pulse when J2 is captured
//
// ADDR_W is expected to be 2*DATA_W.
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | no request outstanding; waits for start
// FETCH_J1 | request outstanding at base, capture into j1
// FETCH_J2 | request outstanding at base+1, capture into j2

module j_fetch_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_oper_addr,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_j1,
    output logic [DATA_W-1:0] o_j2,
    output logic              o_j_valid,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_J1 = 2'd1,
        FETCH_J2 = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_j1;
    logic [DATA_W-1:0] r_j2;
    logic              r_j_valid;
    logic              r_busy;
    logic              r_done;

    // Wraps modulo 2^ADDR_W, so base 'hFFFF reads J2 from 'h0000.
    logic [ADDR_W-1:0] w_base_p1;
    assign w_base_p1 = r_base + ADDR_W'(1);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_j1       <= '0;
            r_j2       <= '0;
            r_j_valid  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Stray acks are ignored here; start together with abort is dropped.
                    if (i_start && !i_abort) begin
                        r_base     <= i_oper_addr;
                        r_mem_addr <= i_oper_addr;
                        r_mem_req  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_j_valid  <= 1'b0;
                        r_state    <= FETCH_J1;
                    end
                end
                FETCH_J1: begin
                    if (i_abort) begin
                        r_mem_req <= 1'b0;
                        r_busy    <= 1'b0;
                        r_j_valid <= 1'b0;
                        r_state   <= IDLE;
                    end else if (i_mem_ack) begin
                        // Request stays asserted; the J2 read starts next cycle.
                        r_j1       <= i_mem_rdata;
                        r_mem_addr <= w_base_p1;
                        r_state    <= FETCH_J2;
                    end
                end
                FETCH_J2: begin
                    // Abort wins over a coincident ack, so j2 is not overwritten.
                    if (i_abort) begin
                        r_mem_req <= 1'b0;
                        r_busy    <= 1'b0;
                        r_j_valid <= 1'b0;
                        r_state   <= IDLE;
                    end else if (i_mem_ack) begin
                        r_j2      <= i_mem_rdata;
                        r_j_valid <= 1'b1;
                        r_done    <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign o_mem_req  = r_mem_req;
    assign o_mem_addr = r_mem_addr;
    assign o_j1       = r_j1;
    assign o_j2       = r_j2;
    assign o_j_valid  = r_j_valid;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_j_fetch_unit.sv
// Directed bench for j_fetch_unit. Inputs change 1 time unit after the
// rising edge and outputs are checked at the same point, so every check
// sees the registers updated by the edge just passed.
module tb_j_fetch_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] oper_addr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [7:0]  j1;
    logic [7:0]  j2;
    logic        j_valid;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    j_fetch_unit #(.DATA_W(8), .ADDR_W(16)) dut (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_start     (start),
        .i_abort     (abort),
        .i_oper_addr (oper_addr),
        .o_mem_req   (mem_req),
        .o_mem_addr  (mem_addr),
        .i_mem_ack   (mem_ack),
        .i_mem_rdata (mem_rdata),
        .o_j1        (j1),
        .o_j2        (j2),
        .o_j_valid   (j_valid),
        .o_busy      (busy),
        .o_done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Snapshot of every output against expected values.
    task automatic check_all(input string tag, input logic req, input logic [15:0] addr,
                             input logic [7:0] e_j1, input logic [7:0] e_j2,
                             input logic vld, input logic bsy, input logic dn);
        check({tag, ".mem_req"},  mem_req,  req);
        check({tag, ".mem_addr"}, mem_addr, addr);
        check({tag, ".j1"},       j1,       e_j1);
        check({tag, ".j2"},       j2,       e_j2);
        check({tag, ".j_valid"},  j_valid,  vld);
        check({tag, ".busy"},     busy,     bsy);
        check({tag, ".done"},     done,     dn);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        oper_addr = 16'h0;
        mem_ack   = 1'b0;
        mem_rdata = 8'h0;
        tick();
        tick();
        check_all("reset", 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0);
        reset = 1'b0;

        // Basic fetch, ack in the first request cycle.
        oper_addr = 16'h1234;
        start     = 1'b1;
        tick();                                     // cycle 1
        start = 1'b0;
        check_all("basic.c1", 1, 16'h1234, 8'h00, 8'h00, 0, 1, 0);
        mem_ack = 1'b1; mem_rdata = 8'hAB;
        tick();                                     // cycle 2
        check_all("basic.c2", 1, 16'h1235, 8'hAB, 8'h00, 0, 1, 0);
        mem_rdata = 8'hCD;
        tick();                                     // cycle 3
        mem_ack = 1'b0;
        check_all("basic.c3", 0, 16'h1235, 8'hAB, 8'hCD, 1, 0, 1);
        tick();
        check_all("basic.c4", 0, 16'h1235, 8'hAB, 8'hCD, 1, 0, 0);

        // Wait states: four idle request cycles before each ack; oper_addr moved mid-fetch.
        oper_addr = 16'h1234;
        start     = 1'b1;
        tick();                                     // cycle 1
        start     = 1'b0;
        oper_addr = 16'h0000;
        for (int c = 1; c <= 4; c++) begin
            check_all($sformatf("wait.j1.c%0d", c), 1, 16'h1234, 8'hAB, 8'hCD, 0, 1, 0);
            tick();
        end
        check_all("wait.j1.c5", 1, 16'h1234, 8'hAB, 8'hCD, 0, 1, 0);
        mem_ack = 1'b1; mem_rdata = 8'h5A;
        tick();                                     // cycle 6
        mem_ack = 1'b0;
        for (int c = 6; c <= 9; c++) begin
            check_all($sformatf("wait.j2.c%0d", c), 1, 16'h1235, 8'h5A, 8'hCD, 0, 1, 0);
            tick();
        end
        check_all("wait.j2.c10", 1, 16'h1235, 8'h5A, 8'hCD, 0, 1, 0);
        mem_ack = 1'b1; mem_rdata = 8'hC3;
        tick();                                     // cycle 11
        mem_ack = 1'b0;
        check_all("wait.c11", 0, 16'h1235, 8'h5A, 8'hC3, 1, 0, 1);

        // Address wrap at the top of memory.
        oper_addr = 16'hFFFF;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check_all("wrap.c1", 1, 16'hFFFF, 8'h5A, 8'hC3, 0, 1, 0);
        mem_ack = 1'b1; mem_rdata = 8'h11;
        tick();
        check_all("wrap.c2", 1, 16'h0000, 8'h11, 8'hC3, 0, 1, 0);
        mem_rdata = 8'h22;
        tick();
        mem_ack = 1'b0;
        check_all("wrap.c3", 0, 16'h0000, 8'h11, 8'h22, 1, 0, 1);

        // Stray acks in IDLE leave everything alone.
        mem_ack = 1'b1; mem_rdata = 8'hEE;
        tick();
        tick();
        mem_ack = 1'b0;
        check_all("stray_ack", 0, 16'h0000, 8'h11, 8'h22, 1, 0, 0);

        // Start while busy is dropped; base holds against a new oper_addr.
        oper_addr = 16'h2000;
        start     = 1'b1;
        tick();
        oper_addr = 16'h3000;
        check_all("busy_start.c1", 1, 16'h2000, 8'h11, 8'h22, 0, 1, 0);
        tick();
        check_all("busy_start.c2", 1, 16'h2000, 8'h11, 8'h22, 0, 1, 0);
        mem_ack = 1'b1; mem_rdata = 8'h33;
        tick();
        check_all("busy_start.c3", 1, 16'h2001, 8'h33, 8'h22, 0, 1, 0);
        mem_rdata = 8'h44;
        tick();
        mem_ack = 1'b0;
        start   = 1'b0;
        check_all("busy_start.c4", 0, 16'h2001, 8'h33, 8'h44, 1, 0, 1);
        tick();
        check_all("busy_start.c5", 0, 16'h2001, 8'h33, 8'h44, 1, 0, 0);

        // start with abort in IDLE is ignored.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check_all("start_abort_idle", 0, 16'h2001, 8'h33, 8'h44, 1, 0, 0);

        // Abort in FETCH_J2 coincident with ack.
        oper_addr = 16'h4000;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check_all("abort.c1", 1, 16'h4000, 8'h33, 8'h44, 0, 1, 0);
        mem_ack = 1'b1; mem_rdata = 8'h55;
        tick();
        check_all("abort.c2", 1, 16'h4001, 8'h55, 8'h44, 0, 1, 0);
        mem_rdata = 8'h66;
        abort     = 1'b1;
        tick();
        mem_ack = 1'b0;
        abort   = 1'b0;
        check_all("abort.c3", 0, 16'h4001, 8'h55, 8'h44, 0, 0, 0);
        tick();
        check_all("abort.c4", 0, 16'h4001, 8'h55, 8'h44, 0, 0, 0);

        // Valid fetch, then reset while in FETCH_J1.
        oper_addr = 16'h5000;
        start     = 1'b1;
        tick();
        start = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'h77;
        tick();
        mem_rdata = 8'h88;
        tick();
        mem_ack = 1'b0;
        check_all("pre_reset", 0, 16'h5001, 8'h77, 8'h88, 1, 0, 1);
        oper_addr = 16'h6000;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check_all("mid_reset.fetch", 1, 16'h6000, 8'h77, 8'h88, 0, 1, 0);
        reset   = 1'b1;
        mem_ack = 1'b1; mem_rdata = 8'hF0;
        tick();
        reset   = 1'b0;
        mem_ack = 1'b0;
        check_all("mid_reset.after", 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0);

        // Fresh fetch after reset.
        oper_addr = 16'h7000;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check_all("post_reset.c1", 1, 16'h7000, 8'h00, 8'h00, 0, 1, 0);
        mem_ack = 1'b1; mem_rdata = 8'h99;
        tick();
        check_all("post_reset.c2", 1, 16'h7001, 8'h99, 8'h00, 0, 1, 0);
        mem_rdata = 8'hA5;
        tick();
        mem_ack = 1'b0;
        check_all("post_reset.c3", 0, 16'h7001, 8'h99, 8'hA5, 1, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
